mux4_ser: RTL and testbench
===========================

MUX4_SER -- requirements
Module: mux4_ser

Interface
REQ-001 SHALL provide parameter: HOLD, default 1, clock cycles each select value is held; legal range 1..16.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: in  input  4  parallel word to serialize.
REQ-005 SHALL have port: in_valid  input  1  word on in is offered.
REQ-006 SHALL have port: in_ready  output  1  block accepts the word this cycle; combinational from state.
REQ-007 SHALL have port: sel  output  2  current select value; also drives an external 4:1 mux select.
REQ-008 SHALL have port: out  output  1  serial bit, equal to buffered in[sel].
REQ-009 SHALL have port: out_valid  output  1  out carries a valid bit.
REQ-010 SHALL have port: done  output  1  one-cycle pulse on the last bit cycle of a word.

Function
REQ-011 SHALL implement a two-state FSM: IDLE and SEND.
REQ-012 In IDLE: in_ready=1, out_valid=0, out=0, done=0.
REQ-013 A handshake SHALL occur on a rising edge with in_valid=1 and in_ready=1; in is latched into a 4-bit buffer, sel loads its first value, hold counter clears, FSM enters SEND.
REQ-014 First out_valid cycle SHALL be the cycle after the handshake edge; latency 1 cycle.
REQ-015 In SEND: out_valid=1 and out=buffer[sel].
REQ-016 The hold counter (4 bits) SHALL increment every SEND cycle; at HOLD-1 it clears and sel advances.
REQ-017 The last bit cycle is last sel value with counter=HOLD-1; done=1 in that cycle only.
REQ-018 A word SHALL occupy exactly 4*HOLD consecutive out_valid cycles.
REQ-019 In SEND, in_ready=0 except during the last bit cycle, where in_ready=1.
REQ-020 A handshake in the last bit cycle SHALL start the next word with no gap (back-to-back); otherwise the FSM returns to IDLE.
REQ-021 Changes on in or in_valid while in_ready=0 SHALL be ignored; the buffer holds the accepted word.
REQ-022 sel SHALL hold its last value in IDLE.

Reset
REQ-023 rst=1 at a rising edge SHALL force IDLE, sel=0, counter=0, buffer=0, regardless of state.
REQ-024 Reset values: out=0, out_valid=0, done=0, sel=0; in_ready=1 in the first cycle after rst deasserts.
REQ-025 Reset mid-word SHALL discard the word; done SHALL NOT pulse for it.

Configuration
REQ-026 Macro MUX4_SER_MSB_FIRST_EN SHALL select the bit order.
REQ-027 Without the macro, sel sequence SHALL be 0,1,2,3 (LSB first); last value 3.
REQ-028 With the macro, sel sequence SHALL be 3,2,1,0 (MSB first); last value 0.
REQ-029 The reset value of sel SHALL be 0 in both builds.

Verification
REQ-030 LSB build, HOLD=1: after reset, in=4'b0110 valid 1 cycle -> sel 0,1,2,3; out 0,1,1,0; done in 4th cycle; in_ready 0,0,0,1.
REQ-031 Back-to-back: in=4'b0001 then 4'b1000, in_valid held -> 8 consecutive out_valid cycles; out 1,0,0,0,0,0,0,1; done in cycles 4 and 8.
REQ-032 HOLD=3: in=4'b1010 -> out 0,0,0,1,1,1,0,0,0,1,1,1; done in cycle 12 only.
REQ-033 Busy input ignored: accept 4'b1111, set in=4'b0000 with in_valid=1 in cycle 2 -> out stays 1,1,1,1.
REQ-034 Reset mid-word: rst in the sel=2 cycle -> next cycle out_valid=0, sel=0, no done; next word 4'b0011 serializes as 1,1,0,0.
REQ-035 MSB build, HOLD=1: in=4'b0001 -> sel 3,2,1,0; out 0,0,0,1; done with sel=0.

Source files
------------

// File: rtl/mux4_ser.sv
// mux4_ser -- 4-bit parallel-to-serial converter driving an external 4:1 mux.
//
// Purpose:
//   A 4-bit word is accepted on a valid/ready handshake and stored in a buffer.
//   It is then sent one bit at a time on 'out'. Each select value is held for
//   HOLD clock cycles. 'sel' is also brought out so it can drive the select
//   input of an external 4:1 mux in step with 'out'.
//
// Configuration:
//   MUX4_SER_MSB_FIRST_EN  when defined, sel runs 3,2,1,0 (MSB first).
//                          When undefined (the default), sel runs 0,1,2,3.
//
// Parameters:
//   HOLD       number of cycles each select value is held. The legal range
//              is 1..16.
//
// Ports:
//   clk        input   single clock; all state changes on the rising edge
//   rst        input   synchronous, active-high reset
//   in[3:0]    input   parallel word to serialize
//   in_valid   input   the word on 'in' is offered
//   in_ready   output  the block accepts the word this cycle (decoded from state)
//   sel[1:0]   output  current select value
//   out        output  serial bit, equal to buffer[sel] while sending
//   out_valid  output  'out' carries a valid bit
//   done       output  one-cycle pulse on the last bit cycle of a word
//
// Handshake:
//   A word is transferred on a rising edge where in_valid and in_ready are
//   both 1. While in_ready is 0, 'in' and in_valid are ignored. in_ready does
//   not depend on in_valid. It is 1 in IDLE and in the last bit cycle of a
//   word. The last bit cycle is what allows back-to-back words with no gap.
//
// Debug:
//   The FSM state is held in the signal 'state' (type state_t). A checker can
//   read it through the hierarchy.

module mux4_ser #(
  parameter int unsigned HOLD = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [1:0] sel,
  output logic       out,
  output logic       out_valid,
  output logic       done
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // The hold counter ends its count at HOLD-1. A HOLD of 16 uses the full
  // 4-bit range.
  localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

`ifdef MUX4_SER_MSB_FIRST_EN
  localparam logic [1:0] SEL_FIRST = 2'd3;
  localparam logic [1:0] SEL_LAST  = 2'd0;
  localparam logic [1:0] SEL_STEP  = 2'd3;  // adding 3 modulo 4 steps sel down by one
`else
  localparam logic [1:0] SEL_FIRST = 2'd0;
  localparam logic [1:0] SEL_LAST  = 2'd3;
  localparam logic [1:0] SEL_STEP  = 2'd1;
`endif

  state_t     state;
  logic [3:0] word_q;
  logic [3:0] cnt;
  logic       last_cycle;

  // The last bit cycle of a word: the final select value with its hold
  // interval about to end.
  assign last_cycle = (state == SEND) && (sel == SEL_LAST) && (cnt == HOLD_LAST);

  assign in_ready  = (state == IDLE) || last_cycle;
  assign out_valid = (state == SEND);
  assign out       = (state == SEND) ? word_q[sel] : 1'b0;
  assign done      = last_cycle;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sel    <= 2'd0;
      cnt    <= 4'd0;
      word_q <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          // sel keeps its last value while the block is idle.
          if (in_valid) begin
            word_q <= in;
            sel    <= SEL_FIRST;
            cnt    <= 4'd0;
            state  <= SEND;
          end
        end
        SEND: begin
          if (cnt == HOLD_LAST) begin
            cnt <= 4'd0;
            if (sel == SEL_LAST) begin
              if (in_valid) begin
                // A handshake in the last bit cycle starts the next word
                // on the following cycle, with no idle cycle between words.
                word_q <= in;
                sel    <= SEL_FIRST;
                state  <= SEND;
              end else begin
                state <= IDLE;
              end
            end else begin
              sel <= sel + SEL_STEP;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_ser.sv
// tb_mux4_ser -- directed bench for mux4_ser.
// Two instances share the clock: u_h1 has HOLD=1 and u_h3 has HOLD=3.
// Expected values are computed by hand. Where the expected value depends on
// bit order, bit_idx() gives the select value for each bit position in the
// current build.

module tb_mux4_ser;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1, v1, rst3, v3;
  logic [3:0] in1, in3;
  logic       rdy1, out1, ov1, done1;
  logic [1:0] sel1;
  logic       rdy3, out3, ov3, done3;
  logic [1:0] sel3;

  int vectors     = 0;
  int miscompares = 0;

  mux4_ser #(.HOLD(1)) u_h1 (
    .clk(clk), .rst(rst1), .in(in1), .in_valid(v1), .in_ready(rdy1),
    .sel(sel1), .out(out1), .out_valid(ov1), .done(done1)
  );

  mux4_ser #(.HOLD(3)) u_h3 (
    .clk(clk), .rst(rst3), .in(in3), .in_valid(v3), .in_ready(rdy3),
    .sel(sel3), .out(out3), .out_valid(ov3), .done(done3)
  );

  // Select value used for the i-th bit of a word.
  function automatic logic [1:0] bit_idx(input int i);
`ifdef MUX4_SER_MSB_FIRST_EN
    return 2'(3 - i);
`else
    return 2'(i);
`endif
  endfunction

  // ---------------- scoreboard check ----------------
  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle. Outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // The HOLD=1 instance must be in the first out_valid cycle of word w when
  // this task is called. After the first cycle has been checked, the bench
  // drives busy_w/busy_v (the DUT must ignore them). In the last bit cycle
  // it drives nw/nv as the next offer.
  task automatic word1(input string tag, input logic [3:0] w,
                       input logic [3:0] busy_w, input logic busy_v,
                       input logic [3:0] nw, input logic nv);
    logic [1:0] k;
    for (int i = 0; i < 4; i++) begin
      k = bit_idx(i);
      chk({tag, "_sel"},   {2'b00, sel1}, {2'b00, k});
      chk({tag, "_out"},   {3'b000, out1}, {3'b000, w[k]});
      chk({tag, "_ov"},    {3'b000, ov1}, 4'd1);
      chk({tag, "_done"},  {3'b000, done1}, (i == 3) ? 4'd1 : 4'd0);
      chk({tag, "_ready"}, {3'b000, rdy1}, (i == 3) ? 4'd1 : 4'd0);
      if (i == 0) begin in1 = busy_w; v1 = busy_v; end
      if (i == 3) begin in1 = nw;     v1 = nv;     end
      tick();
    end
  endtask

  task automatic idle1(input string tag, input logic [1:0] exp_sel);
    chk({tag, "_ov"},    {3'b000, ov1}, 4'd0);
    chk({tag, "_out"},   {3'b000, out1}, 4'd0);
    chk({tag, "_done"},  {3'b000, done1}, 4'd0);
    chk({tag, "_ready"}, {3'b000, rdy1}, 4'd1);
    chk({tag, "_sel"},   {2'b00, sel1}, {2'b00, exp_sel});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [3:0] w3;
    logic [1:0] k;
    rst1 = 1'b1; rst3 = 1'b1; v1 = 1'b0; v3 = 1'b0; in1 = 4'd0; in3 = 4'd0;
    tick();
    tick();
    // Reset state, checked while rst is still asserted.
    idle1("rst_h1", 2'd0);
    chk("rst_h3_ov",  {3'b000, ov3}, 4'd0);
    chk("rst_h3_sel", {2'b00, sel3}, 4'd0);
    chk("rst_h3_done", {3'b000, done3}, 4'd0);
    rst1 = 1'b0; rst3 = 1'b0;
    tick();
    idle1("post_rst", 2'd0);

    // Single word 0110: offered for one cycle.
    in1 = 4'b0110; v1 = 1'b1;
    tick();
    word1("w0110", 4'b0110, 4'b0110, 1'b0, 4'd0, 1'b0);
    idle1("w0110_idle", bit_idx(3));

    // Back-to-back: 0001 then 1000, with in_valid held high.
    in1 = 4'b0001; v1 = 1'b1;
    tick();
    word1("b2b_a", 4'b0001, 4'b0001, 1'b1, 4'b1000, 1'b1);
    word1("b2b_b", 4'b1000, 4'b1000, 1'b0, 4'd0, 1'b0);
    idle1("b2b_idle", bit_idx(3));

    // Busy input ignored: 1111 accepted, then 0000 offered while busy.
    in1 = 4'b1111; v1 = 1'b1;
    tick();
    word1("busy", 4'b1111, 4'b0000, 1'b1, 4'd0, 1'b0);
    idle1("busy_idle", bit_idx(3));

    // Reset in the third bit cycle of word 0101.
    in1 = 4'b0101; v1 = 1'b1;
    tick();
    v1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      k = bit_idx(i);
      chk("rmid_sel", {2'b00, sel1}, {2'b00, k});
      chk("rmid_out", {3'b000, out1}, {3'b000, in1[k] & 1'b0} | {3'b000, k[0] ^ 1'b1});
      if (i < 2) tick();
    end
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    idle1("rmid_after", 2'd0);
    tick();
    idle1("rmid_quiet", 2'd0);
    in1 = 4'b0011; v1 = 1'b1;
    tick();
    word1("w0011", 4'b0011, 4'b0011, 1'b0, 4'd0, 1'b0);
    idle1("w0011_idle", bit_idx(3));

    // HOLD=3 instance: word 1010 takes 12 cycles.
    w3 = 4'b1010;
    in3 = w3; v3 = 1'b1;
    tick();
    v3 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      k = bit_idx(i / 3);
      chk("h3_sel",   {2'b00, sel3}, {2'b00, k});
      chk("h3_out",   {3'b000, out3}, {3'b000, w3[k]});
      chk("h3_ov",    {3'b000, ov3}, 4'd1);
      chk("h3_done",  {3'b000, done3}, (i == 11) ? 4'd1 : 4'd0);
      chk("h3_ready", {3'b000, rdy3}, (i == 11) ? 4'd1 : 4'd0);
      tick();
    end
    chk("h3_idle_ov",   {3'b000, ov3}, 4'd0);
    chk("h3_idle_done", {3'b000, done3}, 4'd0);
    chk("h3_idle_sel",  {2'b00, sel3}, {2'b00, bit_idx(3)});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
